dbg_scan_bridge: RTL



---
 rtl/dbg_scan_pkg.sv | 22 ++
 rtl/dbg_sync_edge.sv | 39 +++
 rtl/dbg_scan_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dbg_scan_pkg.sv
// Shared types and helpers for the debug scan bridge:
// pending-state encoding and IR-to-channel one-hot decode.
package dbg_scan_pkg;

    localparam int MAX_IR_W = 8;
    localparam int MAX_CH   = 1 << MAX_IR_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    function automatic logic [MAX_CH-1:0] onehot(
        input logic [MAX_IR_W-1:0] ir
    );
        logic [MAX_CH-1:0] v;
        v     = '0;
        v[ir] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dbg_sync_edge.sv
// Multi-stage synchroniser for asynchronous scan inputs,
// with rise/fall pulses derived from the synchronised value.
module dbg_sync_edge #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] s,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [STAGES-1:0][W-1:0] chain_q;
    logic [STAGES-1:0][W-1:0] chain_d;
    logic [W-1:0]             prev_q;
    logic [W-1:0]             prev_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
        prev_d  = chain_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign s    = chain_q[STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

endmodule

// File: rtl/dbg_scan_bridge.sv
// Oversampled virtual-JTAG DR bridge: capture/shift register in the clk
// domain, update-DR delivered as a per-channel valid/ready transaction.
module dbg_scan_bridge
    import dbg_scan_pkg::*;
#(
    parameter  int IR_W        = 2,
    parameter  int DR_W        = 38,
    parameter  int SYNC_STAGES = 2,
    parameter  int OVR_W       = 8,
    localparam int NUM_CH      = 1 << IR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tck,
    input  logic                   tdi,
    input  logic [IR_W-1:0]        ir_in,
    input  logic                   vs_cdr,
    input  logic                   vs_sdr,
    input  logic                   vs_udr,
    input  logic                   vs_uir,
    input  logic [NUM_CH*DR_W-1:0] cap_data,
    output logic                   tdo,
    output logic [IR_W-1:0]        ir_q,
    output logic [DR_W-1:0]        jdo,
    output logic [NUM_CH-1:0]      act_valid,
    input  logic [NUM_CH-1:0]      act_ready,
    output logic [OVR_W-1:0]       ovr_cnt,
    output logic                   st_busy
);

    logic [2:0]      e_s, e_rise, e_fall;
    logic [IR_W+2:0] p_s, p_rise, p_fall;

    dbg_sync_edge #(.W(3), .STAGES(SYNC_STAGES)) u_sync_edge (
        .clk  (clk),
        .reset(reset),
        .d    ({vs_uir, vs_udr, tck}),
        .s    (e_s),
        .rise (e_rise),
        .fall (e_fall)
    );

    dbg_sync_edge #(.W(IR_W+3), .STAGES(SYNC_STAGES)) u_sync_lvl (
        .clk  (clk),
        .reset(reset),
        .d    ({ir_in, vs_sdr, vs_cdr, tdi}),
        .s    (p_s),
        .rise (p_rise),
        .fall (p_fall)
    );

    logic            tck_rise, tck_fall, udr_p, uir_p;
    logic            tdi_s, cdr_s, sdr_s;
    logic [IR_W-1:0] ir_in_s;

    assign tck_rise = e_rise[0];
    assign tck_fall = e_fall[0];
    assign udr_p    = e_rise[1];
    assign uir_p    = e_rise[2];
    assign tdi_s    = p_s[0];
    assign cdr_s    = p_s[1];
    assign sdr_s    = p_s[2];
    assign ir_in_s  = p_s[IR_W+2:3];

    logic [DR_W-1:0]   sr_q, sr_d;
    logic              tdo_q, tdo_d;
    logic [IR_W-1:0]   ir_d;
    logic [DR_W-1:0]   jdo_q, jdo_d;
    logic [NUM_CH-1:0] act_valid_q, act_valid_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d;
    state_e            state_q, state_d;
    logic [MAX_CH-1:0] oh_full;

    assign oh_full = onehot(MAX_IR_W'(ir_q));

    always_comb begin
        sr_d        = sr_q;
        tdo_d       = tdo_q;
        ir_d        = ir_q;
        jdo_d       = jdo_q;
        act_valid_d = act_valid_q;
        ovr_d       = ovr_q;
        state_d     = state_q;

        if (tck_rise) begin
            if (cdr_s)
                sr_d = cap_data[int'(ir_q)*DR_W +: DR_W];
            else if (sdr_s)
                sr_d = {tdi_s, sr_q[DR_W-1:1]};
        end
        if (tck_fall)
            tdo_d = sr_q[0];
        if (uir_p)
            ir_d = ir_in_s;

        // A pending update is never replaced: accept frees the slot first.
        unique case (state_q)
            ST_IDLE: begin
                if (udr_p) begin
                    jdo_d       = sr_q;
                    act_valid_d = oh_full[NUM_CH-1:0];
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                if (|(act_valid_q & act_ready)) begin
                    act_valid_d = '0;
                    state_d     = ST_IDLE;
                end
                if (udr_p && ovr_q != '1)
                    ovr_d = ovr_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q        <= '0;
            tdo_q       <= 1'b0;
            ir_q        <= '0;
            jdo_q       <= '0;
            act_valid_q <= '0;
            ovr_q       <= '0;
            state_q     <= ST_IDLE;
        end else begin
            sr_q        <= sr_d;
            tdo_q       <= tdo_d;
            ir_q        <= ir_d;
            jdo_q       <= jdo_d;
            act_valid_q <= act_valid_d;
            ovr_q       <= ovr_d;
            state_q     <= state_d;
        end
    end

    assign tdo       = tdo_q;
    assign jdo       = jdo_q;
    assign act_valid = act_valid_q;
    assign ovr_cnt   = ovr_q;
    assign st_busy   = (state_q == ST_PEND);

    logic unused_ok;
    assign unused_ok = ^{e_s, e_fall[2:1], p_rise, p_fall, oh_full};

endmodule
